pf_to_ieee754: RTL and testbench

Result-side converter for the floating-point unit (`PontosFlutuantes`). It accepts 32-bit results in the team's custom format: 1 sign bit, 6-bit exponent with bias 31, and 25-bit fraction. It pairs each result with its 4-bit status and emits IEEE-754 binary32 words, rounded to nearest-even. It is the consumer end of the FPU's result path: the FPU's data_out/status_out feed it, and its output goes to the host/debug port through a valid/ready handshake.

---
 rtl/pf_to_ieee754.sv | 92 +++++++++
 tb/tb_pf_to_ieee754.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pf_to_ieee754.sv
// Converts FPU custom-format results (1/6/25, bias 31) into IEEE-754 binary32
// words with round-to-nearest-even, through a two-stage valid/ready pipeline.
module pf_to_ieee754 #(
  parameter int COUNT_W = 16
) (
  input  logic               clock_100kHz,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        pf_in,
  input  logic [3:0]         status_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        ieee_out,
  output logic [4:0]         flags_out,
  output logic [COUNT_W-1:0] xfer_count
);

  logic        sign;
  logic [5:0]  exp_c;
  logic [24:0] frac_c;
  logic [7:0]  biased_exp;
  logic        round_up;
  logic [30:0] mag_rounded;
  logic [31:0] conv_word;
  logic        conv_inexact;

  logic        s1_valid;
  logic [31:0] s1_word;
  logic [4:0]  s1_flags;
  logic        adv1;
  logic        adv2;

  assign sign   = pf_in[31];
  assign exp_c  = pf_in[30:25];
  assign frac_c = pf_in[24:0];

  // Rounding adds into {E, fraction} so a fraction carry bumps the exponent.
  always_comb begin
    biased_exp   = {2'b00, exp_c} + 8'd96;
    round_up     = frac_c[1] & (frac_c[0] | frac_c[2]);
    mag_rounded  = {biased_exp, frac_c[24:2]} + 31'(round_up);
    conv_word    = {sign, 31'b0};
    conv_inexact = 1'b0;
    if (exp_c != 6'd0) begin
      conv_word    = {sign, mag_rounded};
      conv_inexact = |frac_c[1:0];
    end
  end

  assign adv2     = !out_valid | out_ready;
  assign adv1     = !s1_valid | adv2;
  assign in_ready = adv1;

  always_ff @(posedge clock_100kHz or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_word  <= '0;
      s1_flags <= '0;
    end else if (adv1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_word  <= conv_word;
        s1_flags <= {conv_inexact, status_in};
      end
    end
  end

  always_ff @(posedge clock_100kHz or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      ieee_out  <= '0;
      flags_out <= '0;
    end else if (adv2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        ieee_out  <= s1_word;
        flags_out <= s1_flags;
      end
    end
  end

  // Counts output handshakes and sticks at all-ones.
  always_ff @(posedge clock_100kHz or negedge reset) begin
    if (!reset) begin
      xfer_count <= '0;
    end else if (out_valid && out_ready && (xfer_count != '1)) begin
      xfer_count <= xfer_count + COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pf_to_ieee754.sv
// Self-checking bench for pf_to_ieee754: arithmetic reference model with an
// expectation queue, plus directed literal cases and randomized traffic.
`timescale 1ns/1ps
module tb_pf_to_ieee754;

  localparam int COUNT_W = 16;

  logic               clk;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [31:0]        pf_in;
  logic [3:0]         status_in;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        ieee_out;
  logic [4:0]         flags_out;
  logic [COUNT_W-1:0] xfer_count;

  int checks   = 0;
  int failures = 0;

  logic [36:0] exp_q[$];
  longint      model_count = 0;
  bit          prev_stall  = 0;
  logic [36:0] prev_out;

  pf_to_ieee754 #(.COUNT_W(COUNT_W)) dut (
    .clock_100kHz(clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .pf_in       (pf_in),
    .status_in   (status_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .ieee_out    (ieee_out),
    .flags_out   (flags_out),
    .xfer_count  (xfer_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Value-level conversion: 1.m scaled by 2^(e-31), rounded to 24 significant bits.
  function automatic logic [36:0] refConvert(input logic [31:0] pf, input logic [3:0] st);
    longint mant;
    longint q;
    longint r;
    int     e;
    int     expo;
    logic [7:0]  eb;
    logic [22:0] fb;
    e = int'(pf[30:25]);
    if (e == 0) return {1'b0, st, pf[31], 31'b0};
    mant = (64'd1 << 25) + longint'(pf[24:0]);
    q    = mant / 4;
    r    = mant % 4;
    if (r > 2 || (r == 2 && (q % 2) == 1)) q = q + 1;
    expo = e - 31 + 127;
    if (q >= (64'd1 << 24)) begin
      q    = q / 2;
      expo = expo + 1;
    end
    eb = expo[7:0];
    fb = q[22:0];
    return {(r != 0), st, pf[31], eb, fb};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] pf, input logic [3:0] st);
    bit accepted;
    accepted  = 0;
    in_valid  = 1'b1;
    pf_in     = pf;
    status_in = st;
    for (int c = 0; c < 50 && !accepted; c++) begin
      @(negedge clk);
      accepted = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!accepted) checkOutput("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic resetDut();
    @(posedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic waitDrain();
    bit done;
    done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(posedge clk);
      #1;
      done = (exp_q.size() == 0) && !out_valid;
    end
    if (!done) checkOutput("drain_timeout", 64'd0, 64'd1);
  endtask

  // Single accept with out_ready high: word must appear one edge after acceptance.
  task automatic sendDirected(input string name, input logic [31:0] pf, input logic [3:0] st,
                              input logic [31:0] want_word, input logic [4:0] want_flags);
    out_ready = 1'b1;
    applyStimulus(pf, st);
    @(posedge clk);
    #1;
    checkOutput({name, "_valid"}, 64'(out_valid), 64'd1);
    checkOutput({name, "_word"},  64'(ieee_out),  64'(want_word));
    checkOutput({name, "_flags"}, 64'(flags_out), 64'(want_flags));
  endtask

  // Scoreboard: every output beat against the model queue, stall stability, counter.
  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      model_count = 0;
      prev_stall  = 0;
    end else begin
      checkOutput("xfer_count", 64'(xfer_count), 64'(model_count));
      if (out_valid) begin
        if (exp_q.size() == 0) checkOutput("unexpected_output", 64'(ieee_out), 64'hFFFF_FFFF_FFFF_FFFF);
        else checkOutput("stream_word", 64'({flags_out, ieee_out}), 64'(exp_q[0]));
      end
      if (prev_stall) checkOutput("stall_stable", 64'({out_valid, flags_out, ieee_out}), 64'({1'b1, prev_out}));
      prev_stall = out_valid && !out_ready;
      prev_out   = {flags_out, ieee_out};
      if (out_valid && out_ready) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        if (model_count < (64'd1 << COUNT_W) - 1) model_count = model_count + 1;
      end
      if (in_valid && in_ready) exp_q.push_back(refConvert(pf_in, status_in));
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [31:0] bp_data [4];
  bit          accepted;

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    pf_in     = '0;
    status_in = '0;
    out_ready = 1'b0;
    #3;
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_ieee_out", 64'(ieee_out), 64'd0);
    checkOutput("reset_flags_out", 64'(flags_out), 64'd0);
    checkOutput("reset_xfer_count", 64'(xfer_count), 64'd0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("post_reset_in_ready", 64'(in_ready), 64'd1);

    sendDirected("one", 32'h3E00_0000, 4'b0001, 32'h3F80_0000, 5'b00001);
    @(posedge clk);
    #1;
    checkOutput("one_xfer_count", 64'(xfer_count), 64'd1);
    sendDirected("two", 32'h4000_0000, 4'b0000, 32'h4000_0000, 5'b00000);
    sendDirected("neg_zero", 32'h8000_0005, 4'b0100, 32'h8000_0000, 5'b00100);
    sendDirected("guard_tie_even", 32'h3E00_0002, 4'b1000, 32'h3F80_0000, 5'b11000);
    sendDirected("guard_tie_odd", 32'h3E00_0006, 4'b0000, 32'h3F80_0002, 5'b10000);
    sendDirected("carry_exp", 32'h3FFF_FFFF, 4'b0000, 32'h4000_0000, 5'b10000);
    sendDirected("max_exp", 32'h7E00_0000, 4'b0010, 32'h4F80_0000, 5'b00010);
    waitDrain();

    // Backpressure: only two results fit while the output is stalled.
    resetDut();
    bp_data[0] = 32'h3E00_0001;
    bp_data[1] = 32'hC200_0004;
    bp_data[2] = 32'h5555_5557;
    bp_data[3] = 32'h0000_0000;
    out_ready = 1'b0;
    applyStimulus(bp_data[0], 4'b0001);
    applyStimulus(bp_data[1], 4'b0010);
    in_valid  = 1'b1;
    pf_in     = bp_data[2];
    status_in = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("bp_in_ready_low", 64'(in_ready), 64'd0);
      checkOutput("bp_first_word", 64'(ieee_out), 64'h3F80_0000);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    applyStimulus(bp_data[2], 4'b0100);
    applyStimulus(bp_data[3], 4'b1000);
    waitDrain();
    checkOutput("bp_xfer_count", 64'(xfer_count), 64'd4);

    // Full throughput: eight back-to-back inputs.
    resetDut();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pf_in     = $urandom;
      status_in = 4'($urandom_range(0, 15));
      @(negedge clk);
      checkOutput("tput_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      if (i >= 1) checkOutput("tput_out_valid", 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    checkOutput("tput_last_valid", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    checkOutput("tput_xfer_count", 64'(xfer_count), 64'd8);
    checkOutput("tput_idle", 64'(out_valid), 64'd0);

    // Randomized traffic with held-until-accepted inputs.
    accepted = 0;
    for (int c = 0; c < 400; c++) begin
      if (!in_valid || accepted) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        pf_in     = $urandom;
        status_in = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 7) == 0) pf_in[30:25] = 6'd0;
        if ($urandom_range(0, 7) == 0) pf_in[30:25] = 6'd63;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      accepted = in_valid && in_ready;
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    waitDrain();
    checkOutput("rand_drained", 64'(exp_q.size()), 64'd0);

    // Reset with two results buffered.
    out_ready = 1'b0;
    applyStimulus(32'h3E00_0000, 4'b0001);
    applyStimulus(32'h4000_0000, 4'b0001);
    checkOutput("mid_pre_valid", 64'(out_valid), 64'd1);
    reset = 1'b0;
    #1;
    checkOutput("mid_reset_valid", 64'(out_valid), 64'd0);
    checkOutput("mid_reset_count", 64'(xfer_count), 64'd0);
    @(negedge clk);
    @(posedge clk);
    #2;
    reset     = 1'b1;
    out_ready = 1'b1;
    applyStimulus(32'hBE80_0000, 4'b0000);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("mid_one_output", 64'(xfer_count), 64'd1);
    checkOutput("mid_idle", 64'(out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
